// File: rtl/pacing_pkg.sv
// pacing_pkg: shared defaults and queue entry type for the pacing scheduler.
package pacing_pkg;
  localparam int N_EVT_DEF = 1;
  localparam int N_PER_DEF = 2;
  localparam int TS_W_DEF = 32;
  localparam int PERIOD_W = 32;
  typedef struct packed {
    logic [N_EVT_DEF+N_PER_DEF-1:0] mask;
    logic [TS_W_DEF-1:0]            ts;
  } sched_entry_t;
endpackage

// File: rtl/pacing_fifo.sv
// pacing_fifo: DEPTH-entry FIFO of pacing entries with occupancy-count full/empty.
module pacing_fifo import pacing_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = sched_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   push_ok,
  output logic   pop_ok
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty;
  entry_t        mem_q [DEPTH];
  always_comb begin
    full    = cnt_q == (AW+1)'(DEPTH);
    empty   = cnt_q == '0;
    pop_ok  = en && pop && !empty;
    // a full queue still accepts when the head leaves in the same cycle
    push_ok = en && push && (!full || pop_ok);
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    rdata   = mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
    if (push_ok && !rst) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/pacing_scheduler.sv
// pacing_scheduler: merges input strobes and periodic deadlines into queued, timestamped pacing masks.
// Optional PACING_SCHED_DROP_CNT_EN adds a saturating drop_cnt output.
module pacing_scheduler import pacing_pkg::*; #(
  parameter int                          N_EVT   = N_EVT_DEF,
  parameter int                          N_PER   = N_PER_DEF,
  parameter logic [N_PER*PERIOD_W-1:0]   PERIODS = {32'd500, 32'd100},
  parameter int                          DEPTH   = 4,
  parameter int                          TS_W    = TS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_EVT-1:0]       new_input,
  input  logic                   eval_ready,
  output logic [N_EVT+N_PER-1:0] pacing,
  output logic                   pacing_valid,
  output logic [TS_W-1:0]        pacing_ts,
  output logic                   q_push,
  output logic                   q_push_valid,
  output logic                   q_pop,
`ifdef PACING_SCHED_DROP_CNT_EN
  output logic [15:0]            drop_cnt,
`endif
  output logic                   q_pop_valid
);
  localparam int M = N_EVT + N_PER;
  typedef struct packed {
    logic [M-1:0]    mask;
    logic [TS_W-1:0] ts;
  } entry_t;
  logic [TS_W-1:0]     ts_q, ts_d, pacing_ts_q, pacing_ts_d;
  logic [PERIOD_W-1:0] cd_q [N_PER];
  logic [PERIOD_W-1:0] cd_d [N_PER];
  logic [N_PER-1:0]    fire;
  logic [M-1:0]        mask, pacing_q, pacing_d;
  logic                pv_q, pv_d, qpush_q, qpush_d, qpushv_q, qpushv_d, qpop_q, qpop_d;
  logic                push_ok, pop_ok;
  entry_t              wdata, head;
  pacing_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .push   (|mask),
    .pop    (eval_ready),
    .wdata  (wdata),
    .rdata  (head),
    .push_ok(push_ok),
    .pop_ok (pop_ok)
  );
  always_comb begin
    for (int j = 0; j < N_PER; j++) begin
      fire[j] = cd_q[j] == '0;
      cd_d[j] = !en ? cd_q[j] : fire[j] ? PERIODS[j*PERIOD_W +: PERIOD_W] - PERIOD_W'(1) : cd_q[j] - PERIOD_W'(1);
    end
    mask        = en ? {fire, new_input} : '0;
    wdata       = {mask, ts_q};
    ts_d        = en ? ts_q + TS_W'(1) : ts_q;
    pacing_d    = pop_ok ? head.mask : pacing_q;
    pacing_ts_d = pop_ok ? head.ts : pacing_ts_q;
    pv_d        = en ? pop_ok : pv_q;
    qpush_d     = en ? |mask : qpush_q;
    qpushv_d    = en ? push_ok : qpushv_q;
    qpop_d      = en ? pop_ok : qpop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      pacing_q    <= '0;
      pacing_ts_q <= '0;
      pv_q        <= 1'b0;
      qpush_q     <= 1'b0;
      qpushv_q    <= 1'b0;
      qpop_q      <= 1'b0;
      for (int j = 0; j < N_PER; j++) cd_q[j] <= PERIODS[j*PERIOD_W +: PERIOD_W] - PERIOD_W'(1);
    end else begin
      ts_q        <= ts_d;
      pacing_q    <= pacing_d;
      pacing_ts_q <= pacing_ts_d;
      pv_q        <= pv_d;
      qpush_q     <= qpush_d;
      qpushv_q    <= qpushv_d;
      qpop_q      <= qpop_d;
      for (int j = 0; j < N_PER; j++) cd_q[j] <= cd_d[j];
    end
  end
`ifdef PACING_SCHED_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  always_comb drop_d = (|mask && !push_ok && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  always_ff @(posedge clk) drop_q <= rst ? 16'd0 : drop_d;
  assign drop_cnt = drop_q;
`endif
  // strobes are qualified by en so a disabled cycle never shows activity
  assign pacing       = pacing_q;
  assign pacing_ts    = pacing_ts_q;
  assign pacing_valid = pv_q && en;
  assign q_push       = qpush_q && en;
  assign q_push_valid = qpushv_q && en;
  assign q_pop        = qpop_q && en;
  assign q_pop_valid  = q_pop;
endmodule

// File: tb/tb_pacing_scheduler.sv
// tb_pacing_scheduler: scoreboard bench for pacing_scheduler.
module tb_pacing_scheduler;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, eval_ready = 1'b0;
  logic [0:0]  new_input = 1'b0;
  logic [2:0]  pacing;
  logic [31:0] pacing_ts;
  logic        pacing_valid, q_push, q_push_valid, q_pop, q_pop_valid;
`ifdef PACING_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  pacing_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .new_input   (new_input),
    .eval_ready  (eval_ready),
    .pacing      (pacing),
    .pacing_valid(pacing_valid),
    .pacing_ts   (pacing_ts),
    .q_push      (q_push),
    .q_push_valid(q_push_valid),
    .q_pop       (q_pop),
`ifdef PACING_SCHED_DROP_CNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .q_pop_valid (q_pop_valid)
  );
  always #5 clk = ~clk;
  typedef struct {logic [2:0] mask; logic [31:0] ts;} ent_t;
  ent_t        sb[$];
  int          checks = 0, failures = 0;
  int          per[2] = '{100, 500};
  int          cd[2];
  logic [31:0] m_ts = 0, e_ts = 0;
  logic [2:0]  e_mask = 0;
  logic        e_pv = 0, e_push = 0, e_pushv = 0, e_pop = 0;
  int          e_drop = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic ni, input logic er);
    logic [1:0] f;
    logic [2:0] mask;
    logic       pop, acc;
    ent_t       h;
    rst = r; en = e; new_input = ni; eval_ready = er;
    @(posedge clk);
    if (r) begin
      m_ts = 0; cd[0] = per[0] - 1; cd[1] = per[1] - 1; sb.delete();
      e_mask = 0; e_ts = 0; e_pv = 0; e_push = 0; e_pushv = 0; e_pop = 0; e_drop = 0;
    end else if (e) begin
      for (int j = 0; j < 2; j++) begin
        f[j] = cd[j] == 0;
        cd[j] = f[j] ? per[j] - 1 : cd[j] - 1;
      end
      mask = {f, ni};
      pop = sb.size() > 0 && er;
      if (pop) begin
        h = sb.pop_front();
        e_mask = h.mask; e_ts = h.ts;
      end
      acc = mask != 0 && sb.size() < 4;
      if (acc) sb.push_back('{mask, m_ts});
      if (mask != 0 && !acc && e_drop < 65535) e_drop++;
      e_pv = pop; e_pop = pop; e_push = mask != 0; e_pushv = acc;
      m_ts++;
    end
    @(negedge clk);
    check("pacing_valid", pacing_valid, e_pv & en);
    check("pacing", pacing, e_mask);
    check("pacing_ts", pacing_ts, e_ts);
    check("q_push", q_push, e_push & en);
    check("q_push_valid", q_push_valid, e_pushv & en);
    check("q_pop", q_pop, e_pop & en);
    check("q_pop_valid", q_pop_valid, e_pop & en);
    check("ts", dut.ts_q, m_ts);
`ifdef PACING_SCHED_DROP_CNT_EN
    check("drop_cnt", drop_cnt, e_drop);
`endif
  endtask
  task automatic run(input int n, input logic er);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, er);
  endtask
  initial begin
    // T1: first periodic release of the 100-cycle stream
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    run(99, 1);
    step(0, 1, 0, 1);
    check("t1_q_push", q_push, 1);
    check("t1_q_push_valid", q_push_valid, 1);
    step(0, 1, 0, 1);
    check("t1_valid", pacing_valid, 1);
    check("t1_pacing", pacing, 3'b010);
    check("t1_pacing_ts", pacing_ts, 99);
    // T2: input merged with a deadline, then both periodic streams together
    step(1, 1, 0, 1);
    run(99, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    check("t2_pacing", pacing, 3'b011);
    check("t2_pacing_ts", pacing_ts, 99);
    run(398, 1);
    step(0, 1, 0, 1); step(0, 1, 0, 1);
    check("t2b_pacing", pacing, 3'b110);
    check("t2b_pacing_ts", pacing_ts, 499);
    // T3: overflow with evaluator stalled
    step(1, 1, 0, 0);
    run(10, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 0);
      if (i == 3) check("t3_accept", q_push_valid, 1);
      if (i >= 4) begin
        check("t3_drop_push", q_push, 1);
        check("t3_drop_valid", q_push_valid, 0);
      end
    end
`ifdef PACING_SCHED_DROP_CNT_EN
    check("t3_drop_cnt", drop_cnt, 2);
`endif
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 1);
      check("t3_rel_valid", pacing_valid, 1);
      check("t3_rel_ts", pacing_ts, 32'(10 + k));
    end
    // T4: push into a full queue while the head pops
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    check("t4_full", dut.u_fifo.cnt_q, 4);
    step(0, 1, 1, 1);
    check("t4_push_valid", q_push_valid, 1);
    check("t4_count", dut.u_fifo.cnt_q, 4);
`ifdef PACING_SCHED_DROP_CNT_EN
    check("t4_drop_cnt", drop_cnt, 2);
`endif
    run(6, 1);
    // T5: disable window with an ignored input pulse
    step(1, 1, 0, 1);
    run(50, 1);
    for (int i = 0; i < 50; i++) step(0, 0, i == 20, 1);
    check("t5_ts_frozen", dut.ts_q, 50);
    run(49, 1);
    step(0, 1, 0, 1); step(0, 1, 0, 1);
    check("t5_pacing", pacing, 3'b010);
    check("t5_pacing_ts", pacing_ts, 99);
    // T6: reset with entries queued
    step(1, 1, 0, 0);
    run(5, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    check("t6_queued", dut.u_fifo.cnt_q, 3);
    step(1, 1, 0, 1);
    check("t6_ts", dut.ts_q, 0);
    check("t6_count", dut.u_fifo.cnt_q, 0);
    step(0, 1, 0, 1);
    check("t6_no_release", pacing_valid, 0);
    run(98, 1);
    step(0, 1, 0, 1); step(0, 1, 0, 1);
    check("t6_pacing", pacing, 3'b010);
    check("t6_pacing_ts", pacing_ts, 99);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pacing_scheduler.md
# pacing_scheduler

Front-end scheduler for the generated stream monitor. Merges asynchronous input-event strobes and internally generated periodic deadlines into timestamped pacing masks. Buffers them in a small event queue and releases one mask per cycle to the evaluation pipeline when it is ready. It drives the `q_push`/`q_pop`/`q_push_valid`/`q_pop_valid` debug strobes and the per-stream pacing vector that the testbench probes.

## Interface
Parameters:
- `N_EVT`, 1: number of event-driven (input) streams.
- `N_PER`, 2: number of periodic streams.
- `PERIODS`, {32'd500, 32'd100}: packed periods in clock cycles, 32 bits each; entry 0 is in the LSBs.
- `DEPTH`, 4: queue entries; must be a power of two and ≥2.
- `TS_W`, 32: timestamp width.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `en` in 1: global enable; state holds while low.
- `new_input` in N_EVT: one-cycle event strobes, bit i = input stream i.
- `eval_ready` in 1: evaluator can accept a pacing mask this cycle.
- `pacing` out N_EVT+N_PER: mask of the released entry. Bits [N_EVT-1:0] are inputs; the upper bits are periodic streams.
- `pacing_valid` out 1: `pacing` and `pacing_ts` are valid this cycle.
- `pacing_ts` out TS_W: timestamp at which the entry was captured.
- `q_push` out 1: the previous enabled cycle had a nonzero event mask.
- `q_push_valid` out 1: that push was accepted.
- `q_pop` out 1: an entry was popped in the previous enabled cycle.
- `q_pop_valid` out 1: the pop delivered data; equals `q_pop`.
- `drop_cnt` out 16: count of dropped pushes; present only with the macro defined.

## Operation
- Timestamp counter `ts` increments on every enabled cycle and wraps modulo 2^TS_W.
- Each periodic stream j has a countdown that loads PERIODS[j]−1.
  - It fires on the enabled cycle where it reads 0, then reloads on that same cycle.
  - Period is exact: stream j fires at ts = k·PERIODS[j]−1.
- Event mask for a cycle = {periodic fires, `new_input`}. A nonzero mask is a push request.
- Push: the entry {mask, ts} is written when the queue is not full, or when it is full but a pop occurs in the same cycle. Otherwise the entry is dropped whole; a partial mask is never stored.
- Pop: fires when the queue is non-empty and `eval_ready`=1. The head entry is registered onto `pacing`/`pacing_ts` with `pacing_valid`=1 for one cycle.
- There is no bypass. A push into an empty queue is popped no earlier than the next cycle.
- Entries leave the queue strictly in FIFO order.
- When `en`=0, the following all hold:
  - Counters, countdowns, queue and `drop_cnt` freeze.
  - `new_input` is ignored.
  - `pacing_valid` and all four `q_*` strobes are 0.
- Reset values: `ts`=0; queue empty; countdowns reloaded; every output 0, including `pacing`, `pacing_ts` and `drop_cnt`.
- Reset asserted mid-operation discards queued entries. Nothing is released in the following cycle.

## Timing
- Capture cycle t with an empty queue and `eval_ready`=1 gives `pacing_valid`=1 at cycle t+2. Breakdown:
  - Cycle t: write.
  - Cycle t+1: pop.
  - Cycle t+2: registered output.
- `q_push`/`q_push_valid` are asserted in cycle t+1 for a push at cycle t. `q_pop`/`q_pop_valid` are asserted together with `pacing_valid`.
- Sustained throughput is one entry per cycle.
- Full and empty are derived from an occupancy count of width $clog2(DEPTH)+1.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- `drop_cnt` saturates at 16'hFFFF.

## Configuration
- `PACING_SCHED_DROP_CNT_EN`
  - Defined: the `drop_cnt` port and a saturating counter exist. The counter increments once per rejected push.
  - Undefined: neither the port nor the counter exists, and drops are visible only as `q_push`=1 with `q_push_valid`=0.
- Queue behaviour is identical in both builds.

## Structure
- Shared package `pacing_pkg` holds:
  - the `sched_entry_t` typedef: mask of N_EVT+N_PER bits plus a TS_W-bit timestamp;
  - the default N_EVT, N_PER and TS_W constants;
  - the `PERIOD_W` = 32 constant.
- One sub-module, `pacing_fifo`: DEPTH × `sched_entry_t` storage, read/write pointers, count, and full/empty flags.
- Countdown generation, mask merge and the output registers live in the top level.

## Test plan
1. Reset, then 100 enabled cycles with `eval_ready`=1 and no inputs → one release with `pacing`=3'b010 and `pacing_ts`=99. `q_push`/`q_push_valid` are asserted at ts 100.
2. `new_input`=1 at ts=99 → a single entry `pacing`=3'b011, `pacing_ts`=99. ts=499 → `pacing`=3'b110, `pacing_ts`=499.
3. `eval_ready`=0 and six input pulses at ts 10–15 →
   - four accepted; the last two show `q_push`=1, `q_push_valid`=0;
   - `drop_cnt`=2 with the macro defined;
   - after `eval_ready`=1, releases with `pacing_ts` 10, 11, 12, 13 on consecutive cycles.
4. Queue full, `eval_ready`=1 and an input pulse in the same cycle → the push is accepted (`q_push_valid`=1), the count stays at 4 and `drop_cnt` is unchanged.
5. `en`=0 for 50 cycles mid-run, with an input pulse during the window → `ts` frozen, no strobes. The pulse is ignored, and the periodic release still occurs at `pacing_ts`=99 after re-enable.
6. `rst` asserted for one cycle with three entries queued → next cycle `pacing_valid`=0, `ts`=0, queue empty. The first periodic release is again at `pacing_ts`=99.
